// File: rtl/vram_arbiter.sv
// vram_arbiter: owns the single port of the 80x60 character RAM. Priority order is clear sweep, then scan-out fetch, then buffered host writes.
// Optional post-reset screen clear is enabled by defining VRAM_CLEAR_EN.
module vram_arbiter #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 60,
  parameter int          ADDR_W     = 13,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  BLANK      = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [6:0]        vid_col,
  input  logic [5:0]        vid_row,
  output logic [7:0]        vid_data,
  output logic              vid_valid,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [6:0]        host_col,
  input  logic [5:0]        host_row,
  input  logic [7:0]        host_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              oob_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [ADDR_W-1:0] f_addr(input logic [6:0] col, input logic [5:0] row);
    return ADDR_W'(32'(row) * COLS + 32'(col));
  endfunction

  function automatic logic f_oob(input logic [6:0] col, input logic [5:0] row);
    return (32'(col) >= COLS) || (32'(row) >= ROWS);
  endfunction

  logic [6:0]        r_fifo_col  [FIFO_DEPTH];
  logic [5:0]        r_fifo_row  [FIFO_DEPTH];
  logic [7:0]        r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [7:0]        r_mem_wdata;
  logic              r_oob_err;
  logic              r_vld_p0, r_blank_p0, r_vld_p1, r_blank_p1;
  logic              r_vid_valid;
  logic [7:0]        r_vid_data;

  logic              w_full, w_empty, w_push, w_pop;
  logic              w_clearing, w_busy;
  logic [ADDR_W-1:0] w_clr_addr, w_vid_addr, w_head_addr;
  logic              w_head_oob;
  logic [7:0]        w_head_data;

`ifdef VRAM_CLEAR_EN
  localparam logic [0:0]        S_RUN     = 1'b0;
  localparam logic [0:0]        S_CLEAR   = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_busy;

  // r_busy lags the state by one cycle so it stays high while the last clear write is on the port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_busy     <= 1'b1;
    end else begin
      r_busy <= (r_state == S_CLEAR);
      if (r_state == S_CLEAR) begin
        if (r_clr_addr == LAST_ADDR) r_state <= S_RUN;
        else                         r_clr_addr <= r_clr_addr + 1'b1;
      end
    end
  end

  assign w_clearing = (r_state == S_CLEAR);
  assign w_clr_addr = r_clr_addr;
  assign w_busy     = r_busy;
`else
  assign w_clearing = 1'b0;
  assign w_clr_addr = '0;
  assign w_busy     = 1'b0;
`endif

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = host_valid && host_ready;
  assign w_pop       = !w_clearing && !vid_req && !w_empty;
  assign w_vid_addr  = f_addr(vid_col, vid_row);
  assign w_head_addr = f_addr(r_fifo_col[r_rd_ptr], r_fifo_row[r_rd_ptr]);
  assign w_head_oob  = f_oob(r_fifo_col[r_rd_ptr], r_fifo_row[r_rd_ptr]);
  assign w_head_data = r_fifo_data[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_col[r_wr_ptr]  <= host_col;
      r_fifo_row[r_wr_ptr]  <= host_row;
      r_fifo_data[r_wr_ptr] <= host_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_oob_err   <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_clearing) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= w_clr_addr;
        r_mem_wdata <= BLANK;
      end else if (vid_req) begin
        r_mem_addr <= w_vid_addr;
      end else if (!w_empty) begin
        // An out-of-range head is consumed without touching the RAM
        if (w_head_oob) begin
          r_oob_err <= 1'b1;
        end else begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= w_head_addr;
          r_mem_wdata <= w_head_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0    <= 1'b0;
      r_blank_p0  <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_blank_p1  <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_data  <= '0;
    end else begin
      // p0: address presented to the RAM
      r_vld_p0   <= vid_req;
      r_blank_p0 <= w_clearing;
      // p1: RAM read in flight
      r_vld_p1   <= r_vld_p0;
      r_blank_p1 <= r_blank_p0;
      // p2: capture read data, or BLANK when the slot belonged to the clear sweep
      r_vid_valid <= r_vld_p1;
      if (r_vld_p1) r_vid_data <= r_blank_p1 ? BLANK : mem_rdata;
    end
  end

  assign host_ready = !w_full && !w_busy;
  assign busy       = w_busy;
  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;
  assign oob_err    = r_oob_err;
  assign vid_valid  = r_vid_valid;
  assign vid_data   = r_vid_data;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: table of host writes / video reads, plus starvation, clear and reset sequences.
module tb_vram_arbiter;
  localparam int         COLS   = 80;
  localparam int         ROWS   = 60;
  localparam int         ADDR_W = 13;
  localparam logic [7:0] BLANK  = 8'h20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              vid_req = 1'b0;
  logic [6:0]        vid_col = '0;
  logic [5:0]        vid_row = '0;
  logic [7:0]        vid_data;
  logic              vid_valid;
  logic              host_valid = 1'b0;
  logic              host_ready;
  logic [6:0]        host_col = '0;
  logic [5:0]        host_row = '0;
  logic [7:0]        host_data = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              oob_err;

  vram_arbiter #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .BLANK(BLANK)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_col(vid_col), .vid_row(vid_row),
    .vid_data(vid_data), .vid_valid(vid_valid),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_col(host_col), .host_row(host_row), .host_data(host_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  // Synchronous single-port RAM; untouched locations read back a fixed pattern
  logic [7:0] ram    [1 << ADDR_W];
  bit         ram_wr [1 << ADDR_W];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));
  end

  logic [7:0] ref_mem [1 << ADDR_W];

  typedef struct { int due; logic [7:0] data; } vexp_t;
  typedef struct { int addr; logic [7:0] data; } wexp_t;
  vexp_t vq[$];
  wexp_t wq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vid_valid) begin
      if (vq.size() == 0 || vq[0].due != edge_cnt) begin
        n_checks++;
        n_fail++;
        $display("FAIL vid_unexpected: actual vid_valid=1 at edge %0d, expected 0", edge_cnt);
      end else begin
        chk("vid_data", vid_data, vq[0].data);
        void'(vq.pop_front());
      end
    end else if (vq.size() != 0 && vq[0].due == edge_cnt) begin
      chk("vid_valid", vid_valid, 1);
      void'(vq.pop_front());
    end
    if (mem_we) begin
      if (wq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL write_unexpected: actual write addr %0d data %0h, expected none", mem_addr, mem_wdata);
      end else begin
        chk("wr_addr", mem_addr, wq[0].addr);
        chk("wr_data", mem_wdata, wq[0].data);
        void'(wq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
`ifdef VRAM_CLEAR_EN
    begin
      bit done = 1'b0;
      for (int i = 0; i < COLS * ROWS; i++) begin
        wq.push_back('{addr: i, data: BLANK});
        ref_mem[i] = BLANK;
      end
      for (int c = 0; c < 6000 && !done; c++) begin
        step();
        vid_req = 1'b0;
        if (c == 100) begin
          chk("clear_busy", busy, 1);
          chk("clear_ready", host_ready, 0);
          // this address is not swept yet, so only BLANK proves the RAM was not read
          vid_req = 1'b1;
          vid_col = 7'd79;
          vid_row = 6'd59;
          vq.push_back('{due: edge_cnt + 3, data: BLANK});
        end
        if (mem_we && mem_addr == 13'(COLS * ROWS - 1)) begin
          chk("clear_last_busy", busy, 1);
          step();
          chk("clear_done_busy", busy, 0);
          chk("clear_done_ready", host_ready, 1);
          done = 1'b1;
        end
      end
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("FAIL clear_timeout: actual no final clear write, expected address %0d", COLS * ROWS - 1);
      end
    end
`else
    step();
    step();
`endif
  endtask

  typedef struct {
    bit         rd;
    logic [6:0] col;
    logic [5:0] row;
    logic [7:0] data;
    bit         we;
    int         addr;
    bit         oob;
  } vec_t;

  vec_t tbl [14];
  bit   exp_busy_rst;
  bit   exp_ready_rst;

  initial begin
    int acc;
    int nwe;
    tbl[0]  = '{0, 7'd3,   6'd2,  8'h41, 1, 163,  0};
    tbl[1]  = '{1, 7'd3,   6'd2,  8'h00, 0, 163,  0};
    tbl[2]  = '{0, 7'd0,   6'd0,  8'h7E, 1, 0,    0};
    tbl[3]  = '{0, 7'd79,  6'd59, 8'hC3, 1, 4799, 0};
    tbl[4]  = '{0, 7'd0,   6'd59, 8'h11, 1, 4720, 0};
    tbl[5]  = '{0, 7'd79,  6'd0,  8'h22, 1, 79,   0};
    tbl[6]  = '{1, 7'd79,  6'd59, 8'h00, 0, 4799, 0};
    tbl[7]  = '{1, 7'd0,   6'd0,  8'h00, 0, 0,    0};
    tbl[8]  = '{1, 7'd10,  6'd10, 8'h00, 0, 810,  0};
    tbl[9]  = '{1, 7'd127, 6'd63, 8'h00, 0, 5167, 0};
    tbl[10] = '{0, 7'd80,  6'd0,  8'h55, 0, 0,    1};
    tbl[11] = '{0, 7'd0,   6'd60, 8'h66, 0, 0,    1};
    tbl[12] = '{0, 7'd5,   6'd5,  8'h33, 1, 405,  1};
    tbl[13] = '{1, 7'd5,   6'd5,  8'h00, 0, 405,  0};

    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = pat(i);
`ifdef VRAM_CLEAR_EN
    exp_busy_rst  = 1'b1;
    exp_ready_rst = 1'b0;
`else
    exp_busy_rst  = 1'b0;
    exp_ready_rst = 1'b1;
`endif

    step();
    step();
    chk("rst_vid_valid", vid_valid, 0);
    chk("rst_vid_data", vid_data, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_oob_err", oob_err, 0);
    chk("rst_busy", busy, exp_busy_rst);
    chk("rst_host_ready", host_ready, exp_ready_rst);
    release_rst();
    step();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rd) begin
        vid_req = 1'b1;
        vid_col = tbl[i].col;
        vid_row = tbl[i].row;
        vq.push_back('{due: edge_cnt + 3, data: ref_mem[tbl[i].addr]});
        step();
        vid_req = 1'b0;
        chk("rd_addr", mem_addr, tbl[i].addr);
        chk("rd_no_we", mem_we, 0);
        step();
        chk("rd_not_early", vid_valid, 0);
        step();
        chk("rd_valid", vid_valid, 1);
        chk("rd_data", vid_data, ref_mem[tbl[i].addr]);
        step();
        chk("rd_one_pulse", vid_valid, 0);
      end else begin
        chk("wr_ready_idle", host_ready, 1);
        host_valid = 1'b1;
        host_col   = tbl[i].col;
        host_row   = tbl[i].row;
        host_data  = tbl[i].data;
        if (tbl[i].we) begin
          wq.push_back('{addr: tbl[i].addr, data: tbl[i].data});
          ref_mem[tbl[i].addr] = tbl[i].data;
        end
        step();
        host_valid = 1'b0;
        chk("wr_ready_after", host_ready, 1);
        chk("wr_we_push_cycle", mem_we, 0);
        step();
        chk("wr_we", mem_we, tbl[i].we);
        if (tbl[i].we) begin
          chk("wr_addr_direct", mem_addr, tbl[i].addr);
          chk("wr_data_direct", mem_wdata, tbl[i].data);
        end
        chk("wr_oob_err", oob_err, tbl[i].oob);
        step();
      end
    end

    // Video held for 8 cycles starves the host; 4 writes fill the FIFO, the 5th waits
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      vid_req = 1'b1;
      vid_col = 7'(i);
      vid_row = 6'd1;
      vq.push_back('{due: edge_cnt + 3, data: ref_mem[80 + i]});
      host_valid = 1'b1;
      host_col   = 7'(20 + acc);
      host_row   = 6'd2;
      host_data  = 8'h60 + 8'(acc);
      chk("starve_ready", host_ready, (i < 4) ? 1 : 0);
      if (host_ready) begin
        wq.push_back('{addr: 180 + acc, data: 8'h60 + 8'(acc)});
        ref_mem[180 + acc] = 8'h60 + 8'(acc);
        acc++;
      end
      step();
      chk("starve_no_we", mem_we, 0);
    end
    vid_req    = 1'b0;
    host_valid = 1'b0;
    chk("starve_accepted", acc, 4);
    nwe = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_we) nwe++;
    end
    chk("drain_writes", nwe, 4);
    chk("drain_ready", host_ready, 1);

    // Reset with 3 entries queued and reads in flight
    vid_req = 1'b1;
    vid_col = 7'd0;
    vid_row = 6'd0;
    for (int i = 0; i < 3; i++) begin
      host_valid = 1'b1;
      host_col   = 7'(1 + i);
      host_row   = 6'd3;
      host_data  = 8'h90 + 8'(i);
      vq.push_back('{due: edge_cnt + 3, data: ref_mem[0]});
      step();
    end
    host_valid = 1'b0;
    vq.push_back('{due: edge_cnt + 3, data: ref_mem[0]});
    step();
    chk("pre_rst_oob", oob_err, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vid_valid", vid_valid, 0);
    chk("mid_rst_vid_data", vid_data, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    chk("mid_rst_oob", oob_err, 0);
    chk("mid_rst_busy", busy, exp_busy_rst);
    chk("mid_rst_ready", host_ready, exp_ready_rst);
    vq.delete();
    wq.delete();
    vid_req = 1'b0;
    step();
    step();
    release_rst();
    nwe = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_we || vid_valid) nwe++;
    end
    chk("post_rst_quiet", nwe, 0);
    chk("post_rst_ready", host_ready, 1);
    chk("post_rst_oob", oob_err, 0);

    vid_req = 1'b1;
    vid_col = 7'd3;
    vid_row = 6'd2;
    vq.push_back('{due: edge_cnt + 3, data: ref_mem[163]});
    step();
    vid_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("vq_drained", vq.size(), 0);
    chk("wq_drained", wq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
